// File: rtl/vedic_pp_accum.sv
// vedic_pp_accum: final accumulation stage of the Vedic multiplier.
// Combines the four 2W-bit partial products into the 4W-bit product using a
// CHUNK-bit full-adder ripple slice, with a registered carry between chunks.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. in_ready is high only in IDLE; out_valid is high only in DONE,
// and out_product stays stable until out_ready completes the transfer.
module vedic_pp_accum #(
  parameter int W     = 16,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2*W-1:0]   q0,
  input  logic [2*W-1:0]   q1,
  input  logic [2*W-1:0]   q2,
  input  logic [2*W-1:0]   q3,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [4*W-1:0]   out_product,
  output logic [1:0]       o_dbg_state
);

  localparam int N_MID = (2 * W) / CHUNK;
  localparam int N_FIN = (3 * W) / CHUNK;
  localparam int IDX_W = $clog2(N_FIN);

  if ((CHUNK <= 0) || ((W % CHUNK) != 0)) begin : g_bad_chunk
    $error("vedic_pp_accum: CHUNK must divide W");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MID  = 2'd1,
    S_FIN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [IDX_W-1:0]   r_idx;
  logic               r_carry;
  logic [2*W-1:0]     r_op1;
  logic [2*W-1:0]     r_op2;
  logic [2*W:0]       r_m;
  logic [4*W-1:0]     r_t;
  logic [4*W-1:0]     r_prod;

  int                 w_base;
  logic [3*W-1:0]     w_m_ext;
  logic [CHUNK-1:0]   w_a;
  logic [CHUNK-1:0]   w_b;
  logic [CHUNK-1:0]   w_sum;
  logic               w_cout;
  logic               w_c;
  logic               w_last_mid;
  logic               w_last_fin;

  assign w_base      = int'(r_idx) * CHUNK;
  // M bits at or above 2W+1 read as zero in the FIN pass.
  assign w_m_ext     = {{(W-1){1'b0}}, r_m};
  assign w_last_mid  = (r_idx == IDX_W'(N_MID - 1));
  assign w_last_fin  = (r_idx == IDX_W'(N_FIN - 1));
  assign out_product = r_prod;
  assign o_dbg_state = r_state;

  // Select slice operands: q1/q2 chunks while forming M, T/M chunks while folding.
  always_comb begin
    w_a = '0;
    w_b = '0;
    if (r_state == S_MID) begin
      w_a = r_op1[w_base +: CHUNK];
      w_b = r_op2[w_base +: CHUNK];
    end else if (r_state == S_FIN) begin
      w_a = r_t[W + w_base +: CHUNK];
      w_b = w_m_ext[w_base +: CHUNK];
    end
  end

  // CHUNK-bit ripple of full-adder cells fed by the registered carry.
  always_comb begin
    w_sum = '0;
    w_c   = r_carry;
    for (int i = 0; i < CHUNK; i++) begin
      w_sum[i] = w_a[i] ^ w_b[i] ^ w_c;
      w_c      = (w_a[i] & w_b[i]) | (w_c & (w_a[i] ^ w_b[i]));
    end
    w_cout = w_c;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state and handshake outputs.
  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next = S_MID;
      end
      S_MID:  if (w_last_mid) w_next = S_FIN;
      S_FIN:  if (w_last_fin) w_next = S_DONE;
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: capture on accept, build M chunk by chunk, then fold M<<W into T.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_op1   <= '0;
      r_op2   <= '0;
      r_m     <= '0;
      r_t     <= '0;
      r_prod  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_op1   <= q1;
            r_op2   <= q2;
            r_t     <= {q3, q0};
            r_m     <= '0;
            r_idx   <= '0;
            r_carry <= 1'b0;
          end
        end
        S_MID: begin
          r_m[w_base +: CHUNK] <= w_sum;
          if (w_last_mid) begin
            r_m[2*W] <= w_cout;
            r_idx    <= '0;
            r_carry  <= 1'b0;
          end else begin
            r_idx    <= r_idx + IDX_W'(1);
            r_carry  <= w_cout;
          end
        end
        S_FIN: begin
          // T[W-1:0] is never written: the low half of q0 passes straight through.
          r_t[W + w_base +: CHUNK] <= w_sum;
          if (w_last_fin) begin
            r_prod  <= {w_sum, r_t[4*W-CHUNK-1:0]};
            r_idx   <= '0;
            r_carry <= 1'b0;
          end else begin
            r_idx   <= r_idx + IDX_W'(1);
            r_carry <= w_cout;
          end
        end
        default: ;
      endcase
    end
  end

  // The product fits in 4W bits, so the last fold can never carry out.
  a_fin_no_carry: assert property (@(posedge clk) disable iff (rst)
    (r_state == S_FIN && w_last_fin) |-> !w_cout);

endmodule
